// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler in front of a single UART transmitter.
// Per-requester FIFOs, round-robin grant, one byte in flight with re-issue on a missed start.
module uart_tx_sched #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req0_valid,
  input  logic [7:0]                   req0_byte,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [7:0]                   req1_byte,
  output logic                         req1_ready,
  output logic [7:0]                   tx_byte,
  output logic                         tx_dv,
  input  logic                         tx_active,
  input  logic                         tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo0_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo1_count,
  output logic                         busy,
  output logic                         grant_last
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACTIVE, WAIT_DONE, GAP} state_t;

  logic [7:0]    mem_q [2][FIFO_DEPTH];
  logic [AW-1:0] wp_q [2];
  logic [AW-1:0] rp_q [2];
  logic [CW-1:0] cnt_q [2];

  state_t     state_q;
  logic [7:0] hold_q;
  logic [1:0] retry_q;
  logic       dv_q;
  logic       busy_q;
  logic       grant_q;

  logic [7:0] in_byte [2];
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] nempty;
  logic       pop_en;
  logic       pop_sel;
  logic [7:0] head;

  // Ready looks only at the registered count, so a full FIFO refuses even while being popped.
  assign req0_ready = rst_n && (cnt_q[0] < FULL);
  assign req1_ready = rst_n && (cnt_q[1] < FULL);

  always_comb begin
    in_byte[0] = req0_byte;
    in_byte[1] = req1_byte;
    push[0]    = req0_valid && req0_ready;
    push[1]    = req1_valid && req1_ready;
    nempty[0]  = (cnt_q[0] != '0);
    nempty[1]  = (cnt_q[1] != '0);
    pop_en     = (state_q == IDLE) && (|nempty) && !tx_active && !tx_done;
    pop_sel    = (&nempty) ? ~grant_q : nempty[1];
    pop[0]     = pop_en && !pop_sel;
    pop[1]     = pop_en && pop_sel;
  end

  assign head = mem_q[pop_sel][rp_q[pop_sel]];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wp_q[i]] <= in_byte[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) wp_q[i] <= wp_q[i] + 1'b1;
        if (pop[i])  rp_q[i] <= rp_q[i] + 1'b1;
        if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (pop[i] && !push[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // tx_dv is registered: it is set on every transition into ISSUE and cleared otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      retry_q <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= 1'b1;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop_en) begin
            hold_q  <= head;
            grant_q <= pop_sel;
            dv_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          retry_q <= '0;
          state_q <= WAIT_ACTIVE;
        end
        WAIT_ACTIVE: begin
          if (tx_active) begin
            state_q <= WAIT_DONE;
          end else if (retry_q == 2'd2) begin
            dv_q    <= 1'b1;
            state_q <= ISSUE;
          end else begin
            retry_q <= retry_q + 2'd1;
          end
        end
        WAIT_DONE: begin
          if (tx_done) state_q <= GAP;
        end
        GAP: begin
          if (!tx_done) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_byte     = hold_q;
  assign tx_dv       = dv_q;
  assign busy        = busy_q;
  assign grant_last  = grant_q;
  assign fifo0_count = cnt_q[0];
  assign fifo1_count = cnt_q[1];

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with a behavioural 4-clocks-per-bit UART transmitter and line receiver.
module tb_uart_tx_sched;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_byte = '0;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_byte = '0;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_byte;
  logic       tx_dv, busy, grant_last;
  logic [2:0] fifo0_count, fifo1_count;

  // Transmitter model state; tx_ignore makes it miss a start pulse.
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_serial = 1'b1;
  logic       tx_ignore = 1'b0;
  logic [9:0] m_sh = '0;
  int         m_st = 0;
  int         m_bit = 0;
  int         m_cnt = 0;

  int errors = 0;
  int checks = 0;
  int frames = 0;

  typedef struct {
    logic [7:0] b;
    logic       g;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] line_q[$];

  uart_tx_sched #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_byte  (req0_byte),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_byte  (req1_byte),
    .req1_ready (req1_ready),
    .tx_byte    (tx_byte),
    .tx_dv      (tx_dv),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .fifo0_count(fifo0_count),
    .fifo1_count(fifo1_count),
    .busy       (busy),
    .grant_last (grant_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (m_st)
      0: begin
        tx_done <= 1'b0;
        if (tx_dv && !tx_ignore) begin
          m_sh      <= {1'b1, tx_byte, 1'b0};
          tx_serial <= 1'b0;
          tx_active <= 1'b1;
          m_bit     <= 0;
          m_cnt     <= 0;
          m_st      <= 1;
        end
      end
      1: begin
        if (m_cnt == CPB - 1) begin
          m_cnt <= 0;
          if (m_bit == 9) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
            tx_serial <= 1'b1;
            m_st      <= 2;
          end else begin
            m_bit     <= m_bit + 1;
            tx_serial <= m_sh[m_bit + 1];
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      default: begin
        tx_done <= 1'b1;
        m_st    <= 0;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_tx(input logic [7:0] b, input logic g);
    exp_q.push_back('{b, g});
  endtask

  task automatic wait_active(input string tag);
    int n = 0;
    while (tx_active !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < 50), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || tx_active !== 1'b0 || tx_done !== 1'b0 ||
            exp_q.size() != 0 || line_q.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < 600), 1);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (tx_dv === 1'b1) begin
            check("dv_into_idle_tx", {tx_active, tx_done}, 0);
            if (exp_q.size() == 0) begin
              check("dv_sb_nonempty", exp_q.size(), 1);
            end else if (tx_ignore) begin
              check("retry_byte", tx_byte, exp_q[0].b);
            end else begin
              e = exp_q.pop_front();
              check("tx_byte", tx_byte, e.b);
              check("grant_last", grant_last, e.g);
              line_q.push_back(e.b);
            end
          end
        end
      end
      begin : receiver
        logic [9:0] fr;
        forever begin
          @(negedge clk);
          if (tx_serial === 1'b0) begin
            repeat (2) @(negedge clk);
            for (int k = 0; k < 10; k++) begin
              fr[k] = tx_serial;
              if (k < 9) repeat (CPB) @(negedge clk);
            end
            frames++;
            if (line_q.size() == 0) check("line_sb_nonempty", line_q.size(), 1);
            else check("line_frame", fr, {1'b1, line_q.pop_front(), 1'b0});
          end
        end
      end
    join_none

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_grant_last", grant_last, 1);
    check("rst_cnt0", fifo0_count, 0);
    check("rst_cnt1", fifo1_count, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready0", req0_ready, 1);
    check("post_rst_ready1", req1_ready, 1);

    // Single byte and minimum latency
    req0_valid = 1'b1; req0_byte = 8'hA5; expect_tx(8'hA5, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    check("lat1_dv", tx_dv, 0);
    check("lat1_cnt0", fifo0_count, 1);
    @(negedge clk);
    check("lat2_dv", tx_dv, 1);
    check("lat2_byte", tx_byte, 8'hA5);
    check("lat2_cnt0", fifo0_count, 0);
    check("lat2_busy", busy, 1);
    @(negedge clk);
    check("lat3_dv", tx_dv, 0);
    wait_idle("single_done");
    check("byte_held", tx_byte, 8'hA5);

    // Round-robin after reset: requester 0 wins the first tie
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_byte = 8'h11; expect_tx(8'h11, 1'b0);
    req1_valid = 1'b1; req1_byte = 8'h21; expect_tx(8'h21, 1'b1);
    @(negedge clk);
    req0_byte = 8'h12; expect_tx(8'h12, 1'b0);
    req1_byte = 8'h22; expect_tx(8'h22, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("rr_done");
    check("rr_cnt0", fifo0_count, 0);
    check("rr_cnt1", fifo1_count, 0);

    // Fill requester 1 while the transmitter is busy
    req0_valid = 1'b1; req0_byte = 8'h30; expect_tx(8'h30, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_active("full_active");
    for (int i = 0; i < 4; i++) begin
      check("full_ready_before", req1_ready, 1);
      req1_valid = 1'b1; req1_byte = 8'h81 + 8'(i); expect_tx(8'h81 + 8'(i), 1'b1);
      @(negedge clk);
    end
    req1_byte = 8'hEE;
    check("full_ready", req1_ready, 0);
    check("full_cnt1", fifo1_count, 4);
    @(negedge clk);
    check("full_reject1", fifo1_count, 4);
    @(negedge clk);
    check("full_reject2", fifo1_count, 4);
    req1_valid = 1'b0;
    wait_idle("full_done");

    // Missed start: re-issue the same byte after three idle cycles, no second pop
    tx_ignore = 1'b1;
    req0_valid = 1'b1; req0_byte = 8'h5A; expect_tx(8'h5A, 1'b0);
    @(negedge clk);
    req0_byte = 8'h5B; expect_tx(8'h5B, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    check("retry_dv1", tx_dv, 1);
    check("retry_byte1", tx_byte, 8'h5A);
    check("retry_cnt_a", fifo0_count, 1);
    @(negedge clk);
    check("retry_wait1", tx_dv, 0);
    @(negedge clk);
    check("retry_wait2", tx_dv, 0);
    tx_ignore = 1'b0;
    @(negedge clk);
    check("retry_wait3", tx_dv, 0);
    @(negedge clk);
    check("retry_dv2", tx_dv, 1);
    check("retry_byte2", tx_byte, 8'h5A);
    check("retry_cnt_b", fifo0_count, 1);
    wait_idle("retry_done");

    // Reset while the scheduler waits for tx_done with three bytes queued
    req0_valid = 1'b1; req0_byte = 8'h61; expect_tx(8'h61, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_active("mid_active");
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1; req1_byte = 8'h62 + 8'(i); expect_tx(8'h62 + 8'(i), 1'b1);
      @(negedge clk);
    end
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_cnt1", fifo1_count, 3);
    rst_n = 1'b0;
    exp_q.delete();  // queued bytes are discarded by the reset
    #1;
    check("mid_rst_cnt0", fifo0_count, 0);
    check("mid_rst_cnt1", fifo1_count, 0);
    check("mid_rst_dv", tx_dv, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant_last, 1);
    check("mid_rst_byte", tx_byte, 8'h00);
    check("mid_rst_ready1", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_byte = 8'h72; expect_tx(8'h72, 1'b0);
    req1_valid = 1'b1; req1_byte = 8'h71; expect_tx(8'h71, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    begin : hold_off
      int n = 0;
      while ((tx_active === 1'b1 || tx_done === 1'b1) && n < 100) begin
        check("mid_no_dv", tx_dv, 0);
        @(negedge clk);
        n++;
      end
      check("mid_frame_ends", (n < 100), 1);
    end
    wait_idle("mid_done");
    check("frame_count", frames, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
